// File: rtl/tube_driver.sv
// tube_driver: eight-digit seven-segment scanner for the memory-mapped tube register.
// Stores land in a pending register and move to the displayed value only at a
// frame boundary, so a digit never changes partway through a scan.
module tube_driver #(
    parameter int SCAN_DIV = 50000,  // cycles each digit stays lit (>= 2)
    parameter bit BLANK_LZ = 1'b1    // 1: blank leading zero digits
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        TubeCtrl,
    input  logic [31:0] write_data,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_disp;
    logic [31:0]      r_pend;
    logic             r_pend_flag;

    logic             w_tick;
    logic             w_wrap;
    logic [4:0]       w_shift;
    logic [3:0]       w_nib;
    logic [31:0]      w_upper;
    logic             w_blank;
    logic [7:0]       w_code;

    // Segment pattern {a,b,c,d,e,f,g,dp} for one hex nibble.
    function automatic logic [7:0] seg_lut(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_lut = 8'hFC;
            4'h1:    seg_lut = 8'h60;
            4'h2:    seg_lut = 8'hDA;
            4'h3:    seg_lut = 8'hF2;
            4'h4:    seg_lut = 8'h66;
            4'h5:    seg_lut = 8'hB6;
            4'h6:    seg_lut = 8'hBE;
            4'h7:    seg_lut = 8'hE0;
            4'h8:    seg_lut = 8'hFE;
            4'h9:    seg_lut = 8'hF6;
            4'hA:    seg_lut = 8'hEE;
            4'hB:    seg_lut = 8'h3E;
            4'hC:    seg_lut = 8'h9C;
            4'hD:    seg_lut = 8'h7A;
            4'hE:    seg_lut = 8'h9E;
            default: seg_lut = 8'h8E;
        endcase
    endfunction

    assign w_tick = (r_scan_cnt == CNT_MAX);
    assign w_wrap = w_tick && (r_idx == 3'd7);

    // Per-digit dwell counter and digit index; the index advances on every tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
        end else if (w_tick) begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values, regardless of statement order.
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Store capture: pending until the frame boundary, or straight through on it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_flag <= 1'b0;
        end else if (TubeCtrl) begin
            if (w_wrap) begin
                r_disp      <= write_data;
                r_pend_flag <= 1'b0;
            end else begin
                r_pend      <= write_data;
                r_pend_flag <= 1'b1;
            end
        end else if (w_wrap && r_pend_flag) begin
            r_disp      <= r_pend;
            r_pend_flag <= 1'b0;
        end
    end

    // Segment code for the digit being scanned, with optional leading-zero blanking.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch forms.
        w_shift = {r_idx, 2'b00};
        w_nib   = r_disp[w_shift +: 4];
        w_upper = r_disp >> w_shift;
        w_blank = BLANK_LZ && (r_idx != 3'd0) && (w_upper == 32'd0);
        w_code  = w_blank ? 8'h00 : seg_lut(w_nib);
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_en  <= 8'h00;
            seg_out <= 8'h00;
        end else begin
            seg_en  <= 8'h01 << r_idx;
            seg_out <= w_code;
        end
    end

endmodule

// File: tb/tb_tube_driver.sv
// tb_tube_driver: drives two tube_driver instances (blanking on and off) with the
// same store traffic and compares their outputs against a cycle-count model.
module tb_tube_driver;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] out_nb;   // instance without leading-zero blanking
        logic [7:0] out_b;    // instance with leading-zero blanking
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        TubeCtrl = 1'b0;
    logic [31:0] write_data = '0;
    logic [7:0]  en_nb, out_nb, en_b, out_b;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    // Reference model: cycles since reset, displayed value, latest pending store.
    int          m_cnt;
    logic [31:0] m_disp;
    logic [31:0] m_pend_val;
    bit          m_pend;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    tube_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .TubeCtrl(TubeCtrl), .write_data(write_data),
        .seg_en(en_nb), .seg_out(out_nb)
    );

    tube_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
        .clock(clock), .reset(reset), .TubeCtrl(TubeCtrl), .write_data(write_data),
        .seg_en(en_b), .seg_out(out_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] digit_code(input logic [31:0] val, input int d, input bit blank_lz);
        logic [3:0] nib;
        nib = 4'((val >> (4 * d)) & 32'hF);
        if (blank_lz && d > 0 && (val >> (4 * d)) == 0) return 8'h00;
        return seg_tab[nib];
    endfunction

    task automatic model_reset();
        m_cnt      = 0;
        m_disp     = '0;
        m_pend_val = '0;
        m_pend     = 1'b0;
    endtask

    // Called at a falling edge: drive one cycle of bus traffic, predict the
    // outputs after the coming rising edge, advance the model, wait a cycle.
    task automatic step(input logic ctl, input logic [31:0] data);
        exp_t e;
        int   d;
        bit   wrap;
        TubeCtrl   = ctl;
        write_data = data;
        d        = (m_cnt / SD) % 8;
        e.en     = 8'(1 << d);
        e.out_nb = digit_code(m_disp, d, 1'b0);
        e.out_b  = digit_code(m_disp, d, 1'b1);
        exp_q.push_back(e);
        wrap = ((m_cnt % FRAME) == FRAME - 1);
        if (ctl) begin
            if (wrap) begin
                m_disp = data;
                m_pend = 1'b0;
            end else begin
                m_pend_val = data;
                m_pend     = 1'b1;
            end
        end else if (wrap && m_pend) begin
            m_disp = m_pend_val;
            m_pend = 1'b0;
        end
        m_cnt++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Idle until the next cycle's frame position equals pos (bounded to one frame).
    task automatic idle_until(input int pos);
        for (int i = 0; i < FRAME && (m_cnt % FRAME) != pos; i++) step(1'b0, '0);
    endtask

    // Called at a falling edge: assert reset between edges, check the
    // asynchronous clear, release at the next falling edge.
    task automatic do_reset();
        TubeCtrl = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("reset_en_nb",  {en_nb, out_nb}, 16'h0000);
        check("reset_en_b",   {en_b,  out_b},  16'h0000);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every post-edge output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_en",      {8'h00, en_nb},  {8'h00, e.en});
                check("seg_en_b",    {8'h00, en_b},   {8'h00, e.en});
                check("seg_out_nb",  {8'h00, out_nb}, {8'h00, e.out_nb});
                check("seg_out_b",   {8'h00, out_b},  {8'h00, e.out_b});
            end
        end
    end

    initial begin
        logic [31:0] data;
        model_reset();
        @(negedge clock);
        do_reset();

        // Idle scan of value 0, then a full scan of 0x89ABCDEF.
        idle(FRAME + 3);
        step(1'b1, 32'h89AB_CDEF);
        idle(2 * FRAME + 1);

        // Leading-zero blanking patterns.
        step(1'b1, 32'h0000_0120);
        idle(2 * FRAME);
        step(1'b1, 32'h0000_0000);
        idle(2 * FRAME);

        // Frame deferral: display 0x1, then writes at digit 3 and digit 5.
        step(1'b1, 32'h1);
        idle_until(0);
        idle(1);
        idle_until(3 * SD);
        step(1'b1, 32'h2);
        idle_until(5 * SD);
        step(1'b1, 32'h3);
        idle(2 * FRAME);

        // Wrap collision: 0x4 pending, 0x5 written on the wrap cycle.
        idle_until(2 * SD);
        step(1'b1, 32'h4);
        idle_until(FRAME - 1);
        step(1'b1, 32'h5);
        idle(2 * FRAME);

        // Reset while a write is pending.
        idle_until(SD);
        step(1'b1, 32'h7);
        idle(3);
        do_reset();
        idle(2 * FRAME);

        // Randomised store traffic with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            data = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0)
                step(1'b1, data);
            else
                step(1'b0, data);
        end
        idle(FRAME + 1);

        @(posedge clock);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
